// File: rtl/bnn_accumulation_stream_if.sv
// rtl/bnn_accumulation_stream_if.sv - beat input, result output and control bundle for the BNN accumulator
interface bnn_accumulation_stream_if #(
  parameter int OUT_CH  = 4,
  parameter int CHUNK   = 16,
  parameter int OUT_BIT = 2,
  parameter int ACC_W   = 12
);

  logic                             clear_i;
  logic                             mode_i;
  logic [OUT_CH-1:0][ACC_W-1:0]     bias_i;
  logic                             in_valid_i;
  logic                             in_ready_o;
  logic [OUT_CH-1:0][CHUNK-1:0]     xnor_i;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [OUT_CH-1:0][OUT_BIT-1:0]   result_o;
  logic [OUT_CH-1:0]                sat_o;

  // Upstream XNOR array / downstream buffer side
  modport master (
    output clear_i, mode_i, bias_i, in_valid_i, xnor_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, sat_o
  );

  // Accumulator side
  modport slave (
    input  clear_i, mode_i, bias_i, in_valid_i, xnor_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, sat_o
  );

endinterface

// File: rtl/bnn_accumulation_stream.sv
// rtl/bnn_accumulation_stream.sv - multi-channel streaming XNOR popcount accumulator with saturate/sign output
module bnn_accumulation_stream #(
  parameter int IN_CNT  = 784,
  parameter int CHUNK   = 16,
  parameter int OUT_CH  = 4,
  parameter int OUT_BIT = 2,
  parameter int ACC_W   = $clog2(IN_CNT) + 2
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  bnn_accumulation_stream_if.slave bus
);

  localparam int BEATS  = (IN_CNT + CHUNK - 1) / CHUNK;
  localparam int LAST_N = IN_CNT - (BEATS - 1) * CHUNK;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic             ONE_BEAT = (BEATS == 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_BIT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (OUT_BIT - 1)));
  localparam logic signed [ACC_W-1:0] ACC_P1  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_M1  = ACC_W'(-1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]                     state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           mode_q;
  logic signed [ACC_W-1:0]        acc_q   [OUT_CH];
  logic [OUT_CH-1:0][OUT_BIT-1:0] result_q;
  logic [OUT_CH-1:0]              sat_q;

  logic                           in_ready;
  logic                           accept;
  logic                           first_beat;
  logic                           last_beat;
  logic                           mode_eff;
  logic signed [ACC_W-1:0]        contrib [OUT_CH];
  logic signed [ACC_W-1:0]        acc_d   [OUT_CH];
  logic [OUT_CH-1:0][OUT_BIT-1:0] result_d;
  logic [OUT_CH-1:0]              sat_d;

  // Handshake: a held result only frees the input once downstream takes it; clear blocks everything
  always_comb begin
    in_ready   = !bus.clear_i && ((state_q != ST_HOLD) || bus.out_ready_i);
    accept     = bus.in_valid_i && in_ready;
    // Both IDLE and HOLD treat an accepted beat as the start of a new frame
    first_beat = (state_q != ST_ACCUM);
    last_beat  = first_beat ? ONE_BEAT : (cnt_q == CNT_LAST);
    mode_eff   = first_beat ? bus.mode_i : mode_q;
  end

  // Per-channel +/-1 contribution of this beat, next sum, and the activation it would produce
  always_comb begin
    result_d = '0;
    sat_d    = '0;
    for (int c = 0; c < OUT_CH; c++) begin
      contrib[c] = '0;
      for (int i = 0; i < CHUNK; i++) begin
        // Padding bits of the short final beat are ignored entirely
        if (!last_beat || (i < LAST_N)) begin
          contrib[c] = contrib[c] + (bus.xnor_i[c][i] ? ACC_P1 : ACC_M1);
        end
      end
      acc_d[c] = (first_beat ? $signed(bus.bias_i[c]) : acc_q[c]) + contrib[c];
      if (mode_eff) begin
        result_d[c] = acc_d[c][ACC_W-1] ? {OUT_BIT{1'b1}} : OUT_BIT'(1);
      end else if (acc_d[c] > SAT_MAX) begin
        result_d[c] = SAT_MAX[OUT_BIT-1:0];
        sat_d[c]    = 1'b1;
      end else if (acc_d[c] < SAT_MIN) begin
        result_d[c] = SAT_MIN[OUT_BIT-1:0];
        sat_d[c]    = 1'b1;
      end else begin
        result_d[c] = acc_d[c][OUT_BIT-1:0];
      end
    end
  end

  // Frame sequencing, accumulation and result registration
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= '0;
      for (int c = 0; c < OUT_CH; c++) acc_q[c] <= '0;
    end else if (bus.clear_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      sat_q    <= '0;
      for (int c = 0; c < OUT_CH; c++) acc_q[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < OUT_CH; c++) acc_q[c] <= acc_d[c];
      if (first_beat) mode_q <= bus.mode_i;
      if (last_beat) begin
        state_q  <= ST_HOLD;
        cnt_q    <= '0;
        result_q <= result_d;
        sat_q    <= sat_d;
      end else begin
        state_q <= ST_ACCUM;
        cnt_q   <= first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end
    end else if ((state_q == ST_HOLD) && bus.out_ready_i) begin
      state_q <= ST_IDLE;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == ST_HOLD);
  assign bus.result_o    = result_q;
  assign bus.sat_o       = sat_q;

endmodule
